pl_trap_csr_unit: RTL

//  Machine-mode trap/CSR responder for the 5-stage pipeline. Consumes trap requests raised by the

---
 rtl/pl_csr_pkg.sv | 37 +++
 rtl/pl_trap_csr_unit_if.sv | 32 +++
 rtl/pl_csr_file.sv | 123 ++++++++++++
 rtl/pl_trap_csr_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/pl_csr_pkg.sv
// Shared encodings for the machine-mode trap/CSR unit: CSR addresses, cause codes,
// CSR operation encodings, FSM states and the read-modify-write helper.
package pl_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_OVF = 4'd3;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'b00,
        CSR_OP_SET   = 2'b01,
        CSR_OP_CLEAR = 2'b10,
        CSR_OP_NONE  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_VECTOR = 2'd2
    } trap_state_e;

    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] cur, logic [31:0] operand);
        case (op)
            CSR_OP_WRITE: csr_apply = operand;
            CSR_OP_SET:   csr_apply = cur | operand;
            CSR_OP_CLEAR: csr_apply = cur & ~operand;
            default:      csr_apply = cur;
        endcase
    endfunction

endpackage

// File: rtl/pl_trap_csr_unit_if.sv
// Pipeline-facing bundle of the trap/CSR unit: trap requests, CSR read/write, redirect.
interface pl_trap_csr_unit_if #(parameter int CAUSE_W = 4);
    logic               trap_ex_v;
    logic               trap_ex_is_intr;
    logic [CAUSE_W-1:0] trap_ex_cause;
    logic [31:0]        trap_pc;
    logic               irq_ext;
    logic [31:0]        intr_pc;
    logic               mret;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_rdata;
    logic               csr_we;
    logic [11:0]        csr_waddr;
    logic [31:0]        csr_wdata;
    logic [1:0]         csr_op;
    logic               flush;
    logic               redirect_v;
    logic [31:0]        redirect_pc;
    logic               busy;

    modport master (
        output trap_ex_v, trap_ex_is_intr, trap_ex_cause, trap_pc, irq_ext, intr_pc, mret,
               csr_addr, csr_we, csr_waddr, csr_wdata, csr_op,
        input  csr_rdata, flush, redirect_v, redirect_pc, busy
    );

    modport slave (
        input  trap_ex_v, trap_ex_is_intr, trap_ex_cause, trap_pc, irq_ext, intr_pc, mret,
               csr_addr, csr_we, csr_waddr, csr_wdata, csr_op,
        output csr_rdata, flush, redirect_v, redirect_pc, busy
    );
endinterface

// File: rtl/pl_csr_file.sv
// M-mode CSR storage with read mux, write/set/clear, and trap/mret update ports.
// TRAP_VECTORED_EN makes mtvec[1:0] writable (modes 00/01 only).
module pl_csr_file
    import pl_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    input  logic [1:0]  op,
    input  logic        irq_ext,
    input  logic        trap_v,
    input  logic        trap_intr,
    input  logic [3:0]  trap_code,
    input  logic [31:0] trap_epc,
    input  logic        mret_v,
    output logic        mst_mie,
    output logic        meie,
    output logic [31:0] mtvec_base,
    output logic        mtvec_vec,
    output logic [31:0] mepc
);

    logic        mst_mpie;
    logic [29:0] mtvec_hi;
    logic [1:0]  mtvec_mode;
    logic [31:0] mepc_q;
    logic        mcause_intr;
    logic [3:0]  mcause_code;

    logic [31:0] mstatus_v, mie_v, mtvec_v, mcause_v, mip_v;
    logic [31:0] wr_cur, wr_nx;

    assign mstatus_v  = {24'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
    assign mie_v      = {20'b0, meie, 11'b0};
    assign mtvec_v    = {mtvec_hi, mtvec_mode};
    assign mcause_v   = {mcause_intr, 27'b0, mcause_code};
    assign mip_v      = {20'b0, irq_ext, 11'b0};
    assign mtvec_base = {mtvec_hi, 2'b00};
    assign mtvec_vec  = (mtvec_mode == 2'b01);
    assign mepc       = mepc_q;

    always_comb begin
        rd_data = 32'b0;
        case (rd_addr)
            CSR_MSTATUS: rd_data = mstatus_v;
            CSR_MIE:     rd_data = mie_v;
            CSR_MTVEC:   rd_data = mtvec_v;
            CSR_MEPC:    rd_data = mepc_q;
            CSR_MCAUSE:  rd_data = mcause_v;
            CSR_MIP:     rd_data = mip_v;
            default:     rd_data = 32'b0;
        endcase
    end

    // Set/clear operate on the architecturally visible value, so masked bits stay masked.
    always_comb begin
        wr_cur = 32'b0;
        case (waddr)
            CSR_MSTATUS: wr_cur = mstatus_v;
            CSR_MIE:     wr_cur = mie_v;
            CSR_MTVEC:   wr_cur = mtvec_v;
            CSR_MEPC:    wr_cur = mepc_q;
            CSR_MCAUSE:  wr_cur = mcause_v;
            default:     wr_cur = 32'b0;
        endcase
        wr_nx = csr_apply(csr_op_e'(op), wr_cur, wdata);
    end

`ifdef TRAP_VECTORED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_mode <= 2'b00;
        end else if (!trap_v && !mret_v && we && waddr == CSR_MTVEC) begin
            mtvec_mode <= (wr_nx[1:0] == 2'b01) ? 2'b01 : 2'b00;
        end
    end
`else
    assign mtvec_mode = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie     <= 1'b0;
            mst_mpie    <= 1'b0;
            meie        <= 1'b0;
            mtvec_hi    <= MTVEC_RESET[31:2];
            mepc_q      <= 32'b0;
            mcause_intr <= 1'b0;
            mcause_code <= 4'b0;
        end else if (trap_v) begin
            mepc_q      <= trap_epc & ~32'h3;
            mcause_intr <= trap_intr;
            mcause_code <= trap_code;
            mst_mpie    <= mst_mie;
            mst_mie     <= 1'b0;
        end else if (mret_v) begin
            mst_mie     <= mst_mpie;
            mst_mpie    <= 1'b1;
        end else if (we) begin
            case (waddr)
                CSR_MSTATUS: begin
                    mst_mie  <= wr_nx[3];
                    mst_mpie <= wr_nx[7];
                end
                CSR_MIE:    meie     <= wr_nx[11];
                CSR_MTVEC:  mtvec_hi <= wr_nx[31:2];
                CSR_MEPC:   mepc_q   <= wr_nx & ~32'h3;
                CSR_MCAUSE: begin
                    mcause_intr <= wr_nx[31];
                    mcause_code <= wr_nx[3:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pl_trap_csr_unit.sv
// Machine-mode trap/CSR responder: accepts exception/interrupt/mret and sequences flush -> redirect.
// Build option TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 01).
//
// state     | meaning
// ST_IDLE   | waiting; accepts one request (exception > interrupt > mret)
// ST_FLUSH  | flush asserted, pipeline front end killed
// ST_VECTOR | redirect_v asserted with the latched target
module pl_trap_csr_unit
    import pl_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter int          CAUSE_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pl_trap_csr_unit_if.slave    bus
);

    trap_state_e state, state_nx;
    logic [31:0] target_q, target_nx;
    logic        take_exc, take_irq, take_mret, accept;
    logic        irq_pend;
    logic [CAUSE_W-1:0] exc_cause;

    logic        mst_mie, meie, mtvec_vec;
    logic [31:0] mtvec_base, mepc;
    logic        trap_v, trap_intr;
    logic [3:0]  trap_code;
    logic [31:0] trap_epc;
    logic        csr_we_ok;

    assign exc_cause = bus.trap_ex_cause;
    assign irq_pend  = bus.irq_ext & mst_mie & meie;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            target_q <= 32'b0;
        end else begin
            state <= state_nx;
            if (accept) target_q <= target_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        take_exc  = 1'b0;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.trap_ex_v)  take_exc  = 1'b1;
                else if (irq_pend)  take_irq  = 1'b1;
                else if (bus.mret)  take_mret = 1'b1;
                if (take_exc || take_irq || take_mret) state_nx = ST_FLUSH;
            end
            ST_FLUSH:  state_nx = ST_VECTOR;
            ST_VECTOR: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        accept = take_exc | take_irq | take_mret;
    end

    // Only interrupts use the vectored offset; exceptions always land on the base.
    always_comb begin
        target_nx = mtvec_base;
        if (take_mret)
            target_nx = mepc;
        else if (take_irq && mtvec_vec)
            target_nx = mtvec_base + {26'b0, CAUSE_MEI, 2'b00};
    end

    assign trap_v    = take_exc | take_irq;
    assign trap_intr = take_exc ? bus.trap_ex_is_intr : 1'b1;
    assign trap_code = take_exc ? 4'(exc_cause) : CAUSE_MEI;
    assign trap_epc  = take_exc ? bus.trap_pc : bus.intr_pc;
    // The writing instruction is flushed on accept, and nothing commits while busy.
    assign csr_we_ok = bus.csr_we && (state == ST_IDLE) && !accept;

    pl_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (bus.csr_addr),
        .rd_data    (bus.csr_rdata),
        .we         (csr_we_ok),
        .waddr      (bus.csr_waddr),
        .wdata      (bus.csr_wdata),
        .op         (bus.csr_op),
        .irq_ext    (bus.irq_ext),
        .trap_v     (trap_v),
        .trap_intr  (trap_intr),
        .trap_code  (trap_code),
        .trap_epc   (trap_epc),
        .mret_v     (take_mret),
        .mst_mie    (mst_mie),
        .meie       (meie),
        .mtvec_base (mtvec_base),
        .mtvec_vec  (mtvec_vec),
        .mepc       (mepc)
    );

    assign bus.flush       = (state == ST_FLUSH);
    assign bus.redirect_v  = (state == ST_VECTOR);
    assign bus.redirect_pc = (state == ST_VECTOR) ? target_q : 32'b0;
    assign bus.busy        = (state != ST_IDLE);

endmodule
